// File: rtl/cnn_settle_detect.sv
// Convergence/timeout detector behind the 4x4 CNN array. It compares one cell per clock using a single subtractor.
// Optional feature macro: SETTLE_SAT_MAP_EN enables the saturated-cell map on result_sat_map.
//
// state   | meaning
// IDLE    | waiting for start
// TRACK   | waiting for the next completed array iteration
// COMPARE | walking cells 0..15 against the snapshot
// DONE    | result presented, waiting for result_ready
module cnn_settle_detect #(
  parameter int WIDTH        = 9,
  parameter int TOL          = 1,
  parameter int STABLE_ITERS = 2,
  parameter int MAX_ITERS    = 255,
  parameter int SAT_LEVEL    = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    iter_done,
  input  logic [16*2*WIDTH-1:0]   y_flat,
  output logic                    busy,
  output logic                    overrun,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [15:0]             result_map,
  output logic                    result_settled,
  output logic [7:0]              result_iters,
  output logic [15:0]             result_sat_map
);

  localparam int YW = 2 * WIDTH;
  localparam int NC = 16;
  localparam logic [7:0]  MAX_CNT    = 8'(MAX_ITERS);
  localparam logic [7:0]  STABLE_CNT = 8'(STABLE_ITERS);
  localparam logic [YW:0] TOL_V      = (YW+1)'(TOL);

  if (MAX_ITERS < 2 || MAX_ITERS > 255 || STABLE_ITERS < 1 || SAT_LEVEL < 1) begin : g_bad_param
    $error("cnn_settle_detect: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, TRACK, COMPARE, DONE} state_t;

  state_t                 state, state_nxt;
  logic [NC*YW-1:0]       snap_flat, cap_flat, done_src;
  logic                   snap_valid, change, change_fin, settle_hit;
  logic [3:0]             idx;
  logic [7:0]             iter_cnt, iter_nxt, stable_cnt, stable_nxt;
  logic [YW-1:0]          cap_cell, snap_cell;
  logic [YW:0]            diff, abs_diff;
  logic                   done_load, done_settled;

  function automatic logic [15:0] sign_map(input logic [NC*YW-1:0] v);
    logic [15:0] m;
    m = '0;
    for (int k = 0; k < NC; k++) m[k] = ~v[k*YW+YW-1];
    return m;
  endfunction

`ifdef SETTLE_SAT_MAP_EN
  localparam logic [YW:0] SAT_V = (YW+1)'(SAT_LEVEL);

  function automatic logic [15:0] sat_map(input logic [NC*YW-1:0] v);
    logic [15:0] m;
    logic [YW:0] x;
    m = '0;
    for (int k = 0; k < NC; k++) begin
      x = {v[k*YW+YW-1], v[k*YW +: YW]};
      if (x[YW]) x = -x;
      m[k] = (x >= SAT_V);
    end
    return m;
  endfunction
`endif

  always_comb begin
    cap_cell   = cap_flat[idx*YW +: YW];
    snap_cell  = snap_flat[idx*YW +: YW];
    // 19-bit difference of two 18-bit values cannot overflow, so negating is safe
    diff       = {cap_cell[YW-1], cap_cell} - {snap_cell[YW-1], snap_cell};
    abs_diff   = diff[YW] ? -diff : diff;
    change_fin = change | (abs_diff > TOL_V);
    iter_nxt   = iter_cnt + 8'd1;
    stable_nxt = change_fin ? 8'd0 : stable_cnt + 8'd1;
    settle_hit = (stable_nxt >= STABLE_CNT);
    done_src   = (state == TRACK) ? y_flat : cap_flat;
  end

  always_comb begin
    state_nxt    = state;
    done_load    = 1'b0;
    done_settled = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = TRACK;
      TRACK: begin
        if (iter_done) begin
          if (!snap_valid) begin
            if (iter_nxt == MAX_CNT) begin
              state_nxt = DONE;
              done_load = 1'b1;
            end
          end else begin
            state_nxt = COMPARE;
          end
        end
      end
      COMPARE: begin
        if (idx == 4'd15) begin
          if (settle_hit) begin
            state_nxt    = DONE;
            done_load    = 1'b1;
            done_settled = 1'b1;
          end else if (iter_nxt == MAX_CNT) begin
            state_nxt = DONE;
            done_load = 1'b1;
          end else begin
            state_nxt = TRACK;
          end
        end
      end
      DONE:    if (result_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_flat      <= '0;
      cap_flat       <= '0;
      snap_valid     <= 1'b0;
      idx            <= '0;
      change         <= 1'b0;
      iter_cnt       <= '0;
      stable_cnt     <= '0;
      overrun        <= 1'b0;
      result_map     <= '0;
      result_settled <= 1'b0;
      result_iters   <= '0;
`ifdef SETTLE_SAT_MAP_EN
      result_sat_map <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            iter_cnt   <= '0;
            stable_cnt <= '0;
            snap_valid <= 1'b0;
            overrun    <= 1'b0;
          end
        end
        TRACK: begin
          if (iter_done) begin
            if (!snap_valid) begin
              snap_flat  <= y_flat;
              snap_valid <= 1'b1;
              iter_cnt   <= iter_nxt;
            end else begin
              cap_flat <= y_flat;
              idx      <= '0;
              change   <= 1'b0;
            end
          end
        end
        COMPARE: begin
          if (iter_done) overrun <= 1'b1;
          snap_flat[idx*YW +: YW] <= cap_cell;
          change <= change_fin;
          idx    <= idx + 4'd1;
          if (idx == 4'd15) begin
            iter_cnt   <= iter_nxt;
            stable_cnt <= stable_nxt;
          end
        end
        default: ;
      endcase
      // on the final compare edge the snapshot equals cap_flat in full
      if (done_load) begin
        result_map     <= sign_map(done_src);
        result_settled <= done_settled;
        result_iters   <= iter_nxt;
`ifdef SETTLE_SAT_MAP_EN
        result_sat_map <= sat_map(done_src);
`endif
      end
    end
  end

`ifndef SETTLE_SAT_MAP_EN
  assign result_sat_map = 16'h0000;
`endif

  assign busy         = (state != IDLE);
  assign result_valid = (state == DONE);

endmodule

// File: tb/tb_cnn_settle_detect.sv
// Scoreboard bench for cnn_settle_detect: a model predicts each run's result, and a monitor checks every transfer.
module tb_cnn_settle_detect;
  localparam int MAXI = 6;
  localparam int STAB = 2;
  localparam int TOLV = 1;

  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, iter_done = 1'b0, result_ready = 1'b0;
  logic [287:0] y_flat = '0;
  logic         busy, overrun, result_valid, result_settled;
  logic [15:0]  result_map, result_sat_map;
  logic [7:0]   result_iters;

  cnn_settle_detect #(.WIDTH(9), .TOL(TOLV), .STABLE_ITERS(STAB), .MAX_ITERS(MAXI), .SAT_LEVEL(256)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .iter_done(iter_done), .y_flat(y_flat),
    .busy(busy), .overrun(overrun), .result_valid(result_valid), .result_ready(result_ready),
    .result_map(result_map), .result_settled(result_settled), .result_iters(result_iters),
    .result_sat_map(result_sat_map));

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] map;
    logic        settled;
    logic [7:0]  iters;
    logic [15:0] sat;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0, bad = 0;
  int   vals[8][16];
  logic held_v = 1'b0;
  exp_t held;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  // Reference: walk iterations as whole arrays and apply the settle/timeout rules
  function automatic void model(output exp_t e, output int npulse);
    int st = 0, last = 0, d;
    bit changed;
    e.iters = 8'd1;
    e.settled = 1'b0;
    for (int i = 1; i < 8 && e.iters < MAXI; i++) begin
      changed = 0;
      for (int k = 0; k < 16; k++) begin
        d = vals[i][k] - vals[i-1][k];
        if (d > TOLV || d < -TOLV) changed = 1;
      end
      e.iters++;
      last = i;
      st = changed ? 0 : st + 1;
      if (st >= STAB) begin
        e.settled = 1'b1;
        break;
      end
    end
    npulse = int'(e.iters);
    for (int k = 0; k < 16; k++) begin
      e.map[k] = (vals[last][k] >= 0);
`ifdef SETTLE_SAT_MAP_EN
      e.sat[k] = (vals[last][k] >= 256 || vals[last][k] <= -256);
`else
      e.sat[k] = 1'b0;
`endif
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && result_valid) begin
      if (held_v) begin
        chk("hold_map", result_map, held.map);
        chk("hold_iters", result_iters, held.iters);
        chk("hold_settled", result_settled, held.settled);
      end else begin
        held_v = 1'b1;
        held.map = result_map;
        held.iters = result_iters;
        held.settled = result_settled;
      end
      if (result_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got result with empty queue, want none");
        end else begin
          e = exp_q.pop_front();
          chk("result_map", result_map, e.map);
          chk("result_settled", result_settled, e.settled);
          chk("result_iters", result_iters, e.iters);
          chk("result_sat_map", result_sat_map, e.sat);
        end
        held_v = 1'b0;
      end
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic drive_y(input int it);
    for (int k = 0; k < 16; k++) y_flat[k*18 +: 18] = 18'(vals[it][k]);
  endtask

  task automatic pulse_iter(input int it);
    drive_y(it);
    iter_done = 1'b1;
    @(posedge clk); #1 iter_done = 1'b0;
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 16; k++) vals[i][k] = v;
  endtask

  task automatic fill_rand();
    int nl, v;
    bit big;
    nl  = int'($urandom_range(0, 3));
    big = 1'($urandom_range(0, 1));
    for (int k = 0; k < 16; k++)
      vals[0][k] = big ? int'($urandom_range(0, 262142)) - 131071 : int'($urandom_range(0, 800)) - 400;
    for (int i = 1; i < 8; i++)
      for (int k = 0; k < 16; k++) begin
        v = vals[i-1][k] + int'($urandom_range(0, 2*nl)) - nl;
        if (v > 131071) v = 131071;
        if (v < -131072) v = -131072;
        vals[i][k] = v;
      end
  endtask

  task automatic do_run(input bit inj_ovr, input bit inj_start, input int hold);
    exp_t e;
    int   np, c;
    model(e, np);
    exp_q.push_back(e);
    result_ready = 1'b0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("overrun_cleared", overrun, 0);
    for (int p = 0; p < np; p++) begin
      pulse_iter(p);
      if (p < np - 1) begin
        if (inj_ovr && p == 1) begin
          repeat (5) @(posedge clk);
          #1;
          for (int k = 0; k < 16; k++) y_flat[k*18 +: 18] = 18'($urandom_range(1000, 5000));
          iter_done = 1'b1;
          @(posedge clk); #1 iter_done = 1'b0;
          chk("overrun_set", overrun, 1);
        end
        if (inj_start && p == 0) begin
          start = 1'b1;
          @(posedge clk); #1 start = 1'b0;
        end
        repeat (40) @(posedge clk);
        #1;
      end else begin
        c = 0;
        while (!result_valid && c < 20) begin
          @(posedge clk); #1;
          c++;
        end
        total++;
        if (!(c == 16 || c == 17)) begin
          bad++;
          $display("FAIL latency: got %0d clocks want 16..17", c);
        end
      end
    end
    // iter_done while DONE must be ignored
    iter_done = 1'b1;
    @(posedge clk); #1 iter_done = 1'b0;
    chk("overrun_in_done", overrun, inj_ovr);
    repeat (hold) @(posedge clk);
    #1;
    chk("valid_held", result_valid, 1);
    chk("busy_in_done", busy, 1);
    result_ready = 1'b1;
    @(posedge clk); #1 result_ready = 1'b0;
    chk("valid_dropped", result_valid, 0);
    chk("busy_idle", busy, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_map", result_map, 0);
    chk("rst_iters", result_iters, 0);

    // reset mid-COMPARE with overrun pending
    fill_const(50);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    pulse_iter(0);
    repeat (10) @(posedge clk);
    #1 pulse_iter(1);
    repeat (3) @(posedge clk);
    #1 iter_done = 1'b1;
    @(posedge clk); #1 iter_done = 1'b0;
    chk("pre_rst_overrun", overrun, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_overrun", overrun, 0);
    chk("midrst_valid", result_valid, 0);
    chk("midrst_map", result_map, 0);
    chk("midrst_iters", result_iters, 0);
    chk("midrst_settled", result_settled, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // convergence with cell 2 negative
    fill_const(100);
    for (int i = 0; i < 8; i++) vals[i][2] = -5;
    do_run(0, 0, 0);

    // tolerance edge: +/-1 settles, +/-2 times out
    fill_const(100);
    for (int i = 0; i < 8; i++) vals[i][0] = (i % 2 == 1) ? 101 : 100;
    do_run(0, 0, 1);
    fill_const(100);
    for (int i = 0; i < 8; i++) vals[i][0] = (i % 2 == 1) ? 102 : 100;
    do_run(0, 0, 2);

    // overrun with discarded iteration
    fill_const(-77);
    do_run(1, 0, 0);

    // backpressure
    fill_const(123);
    vals[0][9] = -9000;
    do_run(0, 0, 10);

    // saturation map pattern
    fill_const(300);
    for (int i = 0; i < 8; i++) vals[i][5] = 10;
    do_run(0, 1, 3);

    for (int r = 0; r < 14; r++) begin
      fill_rand();
      do_run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 5)));
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
